// File: rtl/clk_divider_prog.sv
// clk_divider_prog
//   Runtime-programmable clock divider and strobe generator. Produces a
//   divided clock o_clk (N i_clk cycles per period, active phase first and
//   one cycle longer for odd N) together with one-cycle strobes aligned to
//   the active (o_lead) and idle (o_trail) edges of o_clk.
//
//   Parameters
//     DIV_WIDTH   width of divisor input and internal counter
//     DEFAULT_DIV divisor active after reset
//     IDLE_LEVEL  o_clk level while stopped / during idle phase
//
//   Ports
//     rst          async active-low reset
//     i_clk        system clock
//     i_en         run request (level)
//     i_div        new divisor value
//     i_div_load   pulse: capture i_div as pending divisor
//     o_div_ack    pulse: pending divisor became active
//     o_clk        divided clock (registered)
//     o_lead       pulse: first cycle of active phase
//     o_trail      pulse: first cycle of idle phase after an active phase
//     o_busy       high while a period is in progress
//
//   Optional build macro CLKDIV_BURST_EN adds:
//     i_burst      number of periods for a burst
//     i_burst_go   pulse: start burst (only in IDLE with i_en low)
//     o_burst_done pulse: burst finished (on the edge o_busy falls)
module clk_divider_prog #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 12,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic                 rst,
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_div_load,
  output logic                 o_div_ack,
  output logic                 o_clk,
  output logic                 o_lead,
  output logic                 o_trail,
  output logic                 o_busy
`ifdef CLKDIV_BURST_EN
  ,
  input  logic [7:0]           i_burst,
  input  logic                 i_burst_go,
  output logic                 o_burst_done
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nx;
  logic [DIV_WIDTH-1:0] cnt, cnt_nx;
  logic [DIV_WIDTH-1:0] div_act, div_act_nx;
  logic [DIV_WIDTH-1:0] pend_val, pend_val_nx;
  logic                 pend_flag, pend_flag_nx;
  logic                 clk_nx, lead_nx, trail_nx, busy_nx, ack_nx;

  logic [DIV_WIDTH-1:0] n_eff, h_len, last_cnt;
  logic                 at_last, boundary;
  logic                 start_req, keep_req;

  // Divisors 0 and 1 behave as 2 so both phases are at least one cycle.
  assign n_eff    = (div_act < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_act;
  assign h_len    = n_eff - (n_eff >> 1);
  assign last_cnt = n_eff - DIV_WIDTH'(1);
  assign at_last  = (state == RUN) && (cnt == last_cnt);
  // Divisor may only change between periods so the running one is never cut.
  assign boundary = (state == IDLE) || at_last;

`ifdef CLKDIV_BURST_EN
  logic [7:0] burst_rem, burst_rem_nx;
  logic       burst_on, burst_on_nx;
  logic       burst_start, burst_more, done_nx;

  assign burst_start = (state == IDLE) && !i_en && i_burst_go && (i_burst != 8'd0);
  // burst_rem counts periods left including the one in progress.
  assign burst_more  = burst_on && (burst_rem > 8'd1);
  assign start_req   = i_en || burst_start;
  assign keep_req    = i_en || burst_more;

  always_comb begin
    burst_rem_nx = burst_rem;
    burst_on_nx  = burst_on;
    done_nx      = 1'b0;
    if (burst_start) begin
      burst_rem_nx = i_burst;
      burst_on_nx  = 1'b1;
    end else if (at_last && burst_on) begin
      if (burst_rem > 8'd1) begin
        burst_rem_nx = burst_rem - 8'd1;
      end else begin
        burst_on_nx = 1'b0;
        // Running on under i_en means the burst never "finishes" visibly.
        done_nx     = !i_en;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      burst_rem    <= '0;
      burst_on     <= 1'b0;
      o_burst_done <= 1'b0;
    end else begin
      burst_rem    <= burst_rem_nx;
      burst_on     <= burst_on_nx;
      o_burst_done <= done_nx;
    end
  end
`else
  assign start_req = i_en;
  assign keep_req  = i_en;
`endif

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    div_act_nx   = div_act;
    pend_val_nx  = pend_val;
    pend_flag_nx = pend_flag;
    clk_nx       = IDLE_LEVEL;
    lead_nx      = 1'b0;
    trail_nx     = 1'b0;
    busy_nx      = 1'b0;
    ack_nx       = 1'b0;

    // A load coinciding with the boundary bypasses the pending register.
    if (boundary && (pend_flag || i_div_load)) begin
      div_act_nx   = i_div_load ? i_div : pend_val;
      pend_flag_nx = 1'b0;
      ack_nx       = 1'b1;
    end else if (i_div_load) begin
      pend_val_nx  = i_div;
      pend_flag_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start_req) begin
          state_nx = RUN;
          cnt_nx   = '0;
          clk_nx   = ~IDLE_LEVEL;
          lead_nx  = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      RUN: begin
        if (!at_last) begin
          cnt_nx   = cnt + DIV_WIDTH'(1);
          clk_nx   = (cnt_nx < h_len) ? ~IDLE_LEVEL : IDLE_LEVEL;
          trail_nx = (cnt_nx == h_len);
          busy_nx  = 1'b1;
        end else if (keep_req) begin
          cnt_nx  = '0;
          clk_nx  = ~IDLE_LEVEL;
          lead_nx = 1'b1;
          busy_nx = 1'b1;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      div_act   <= DIV_WIDTH'(DEFAULT_DIV);
      pend_val  <= '0;
      pend_flag <= 1'b0;
      o_clk     <= IDLE_LEVEL;
      o_lead    <= 1'b0;
      o_trail   <= 1'b0;
      o_busy    <= 1'b0;
      o_div_ack <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      div_act   <= div_act_nx;
      pend_val  <= pend_val_nx;
      pend_flag <= pend_flag_nx;
      o_clk     <= clk_nx;
      o_lead    <= lead_nx;
      o_trail   <= trail_nx;
      o_busy    <= busy_nx;
      o_div_ack <= ack_nx;
    end
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
Runtime-programmable clock divider and strobe generator. It drives the serial clock for the display interface and aligned one-cycle strobes for the shift logic, all from the system clock i_clk. It replaces fixed-ratio dividers with:
- a divisor that changes at runtime without glitches;
- exact odd ratios;
- start/stop gating that always completes the current period.

Parameters:
DIV_WIDTH, 16, width of divisor input and internal counter
DEFAULT_DIV, 12, divisor loaded at reset (125 MHz -> ~10.4 MHz)
IDLE_LEVEL, 0, o_clk level when stopped (SPI CPOL)

Ports:
rst  input  1  asynchronous, active-low reset
i_clk  input  1  system clock
i_en  input  1  run request; level-sensitive
i_div  input  DIV_WIDTH  new divisor N (i_clk cycles per output period)
i_div_load  input  1  one-cycle pulse; captures i_div as pending divisor
o_div_ack  output  1  one-cycle pulse when pending divisor becomes active
o_clk  output  1  divided clock, registered
o_lead  output  1  one-cycle pulse, first cycle o_clk shows active level (~IDLE_LEVEL)
o_trail  output  1  one-cycle pulse, first cycle o_clk shows IDLE_LEVEL after an active phase
o_busy  output  1  high while a period is in progress

Behaviour:
- Reset (rst low, async):
  - active divisor = DEFAULT_DIV; pending flag cleared; counter = 0.
  - o_clk = IDLE_LEVEL; o_lead = o_trail = o_div_ack = o_busy = 0.
- Divisor rules:
  - Effective N = max(active divisor, 2); values 0 and 1 are clamped to 2.
  - Active phase H = N - floor(N/2); idle phase L = floor(N/2).
  - Odd N: active phase is one cycle longer.
- Counter runs 0..N-1. o_clk = ~IDLE_LEVEL for counts 0..H-1 and IDLE_LEVEL for counts H..N-1. All outputs are registered.
- States: IDLE, RUN.
- IDLE -> RUN: i_en sampled high.
  - Next edge: count = 0, o_clk active, o_lead = 1, o_busy = 1.
  - Latency from i_en to first active o_clk: 1 cycle.
- RUN, count == N-1:
  - i_en high: wrap to 0 and raise o_lead again, so periods are back to back with no gap.
  - i_en low: go to IDLE; o_clk stays IDLE_LEVEL; o_busy drops on that edge.
- i_en low mid-period: the period always completes; no truncated pulse is produced.
- o_trail fires on the edge where count goes H-1 -> H. In IDLE no strobes fire.
- Divisor load:
  - i_div_load stores i_div as pending; a later load before application overwrites it (last wins).
  - Pending is applied only at a period boundary: on the edge that wraps N-1 -> 0, or on the IDLE -> RUN edge.
  - In IDLE with i_en low, pending is applied on the next edge.
  - o_div_ack pulses on the edge the value is applied.
  - If i_div_load coincides with the boundary edge, the newly presented i_div is applied directly.
- Width rules: counter and compares are DIV_WIDTH bits; max N = 2^DIV_WIDTH - 1; no overflow is possible.

Optional Feature:
Macro CLKDIV_BURST_EN.
- Defined: adds ports
  - i_burst (8-bit): period count;
  - i_burst_go (1-bit pulse): start request;
  - o_burst_done (1-bit pulse): burst finished.
- Burst start: i_burst_go accepted only in IDLE with i_en low. It runs exactly i_burst periods, then returns to IDLE. i_burst = 0 is ignored.
- o_burst_done pulses on the edge o_busy falls after the last period.
- i_burst_go while busy is ignored. i_en high during a burst extends running past the burst end and suppresses o_burst_done.
- Undefined: these ports and their logic are absent; only i_en controls running.

Test Plan:
- Reset defaults: hold rst low 5 cycles with i_en=1 -> o_clk=0, all strobes 0. Release rst -> first o_lead 1 cycle later; o_clk high 6, low 6 cycles repeating.
- Odd divisor: load N=5 in IDLE, then i_en=1 -> o_div_ack next cycle; o_clk 3 high / 2 low; o_lead every 5 cycles; o_trail 3 cycles after each o_lead.
- Mid-run change: running N=12, load N=4 at count 3 -> current period stays 12 cycles; o_div_ack on wrap; subsequent periods 2 high / 2 low; no glitch.
- Clamp and stop: load N=0 -> behaves as N=2 (1 high / 1 low). Drop i_en at count 0 -> period completes; o_busy falls 2 cycles later; o_clk stays 0.
- Async reset mid-operation: assert rst during the active phase -> o_clk and o_busy go to 0 immediately (same cycle, no clock edge needed); divisor returns to 12.
- Burst (CLKDIV_BURST_EN, N=4): i_burst=8, i_burst_go -> exactly 8 o_lead pulses, o_busy high 32 cycles, then one o_burst_done. i_burst_go mid-burst is ignored.
